// File: rtl/vec_alu_sequencer_if.sv
// Handshake bundle between a vector command source, vec_alu_sequencer and the scalar FP ALU.
// The slave modport is the sequencer's view; master is the environment (host plus ALU).
interface vec_alu_sequencer_if #(
  parameter int unsigned VLEN = 4
) ();
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [VLEN*32-1:0]   cmd_a;
  logic [VLEN*32-1:0]   cmd_b;
  logic [3:0]           alu_control;
  logic [31:0]          alu_in1;
  logic [31:0]          alu_in2;
  logic [31:0]          alu_result;
  logic                 alu_zero;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [VLEN*32-1:0]   rsp_data;
  logic [VLEN-1:0]      rsp_zero_mask;
  logic                 rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
    input  cmd_ready, alu_control, alu_in1, alu_in2, rsp_valid, rsp_data, rsp_zero_mask, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_zero, rsp_ready,
    output cmd_ready, alu_control, alu_in1, alu_in2, rsp_valid, rsp_data, rsp_zero_mask, rsp_err
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Issues a VLEN-element MUL/ADD command to the scalar FP ALU one element at a time.
// Optional VSEQ_MUL_ZERO_SKIP_EN: MUL elements with a +/-0 operand bypass the ALU.
module vec_alu_sequencer #(
  parameter int unsigned VLEN    = 4,  // must match the VLEN of the connected interface
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned ADD_LAT = 3
) (
  input logic                i_clk,
  input logic                i_rst_n,
  vec_alu_sequencer_if.slave bus
);

  localparam int unsigned IdxW   = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int unsigned MaxLat = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
  localparam logic [1:0]  OpMul  = 2'b00;
  localparam logic [1:0]  OpAdd  = 2'b01;

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [VLEN*32-1:0]  r_a, r_b, r_data;
  logic [VLEN-1:0]     r_mask;
  logic [1:0]          r_op;
  logic [IdxW-1:0]     r_idx;
  logic [CntW-1:0]     r_cnt;
  logic [3:0]          r_alu_ctrl;
  logic [31:0]         r_alu_in1, r_alu_in2;
  logic                r_rsp_valid, r_err;

  logic                w_accept, w_legal, w_last;
  logic [IdxW-1:0]     w_nidx;
  logic [1:0]          w_nxt_op;
  logic [3:0]          w_nxt_ctrl;
  logic [31:0]         w_nxt_a, w_nxt_b;
  logic                w_nxt_skip, w_cap_skip;
  logic [31:0]         w_skip_val;

  assign w_accept = bus.cmd_valid && (r_state == StIdle);
  assign w_legal  = (bus.cmd_op == OpMul) || (bus.cmd_op == OpAdd);
  assign w_last   = (r_idx == IdxW'(VLEN - 1));
  assign w_nidx   = w_last ? '0 : r_idx + 1'b1;

  // Operands of the element about to start: element 0 straight from the command on accept,
  // otherwise the next latched element.
  assign w_nxt_op   = (r_state == StIdle) ? bus.cmd_op : r_op;
  assign w_nxt_a    = (r_state == StIdle) ? bus.cmd_a[31:0] : r_a[{w_nidx, 5'b0} +: 32];
  assign w_nxt_b    = (r_state == StIdle) ? bus.cmd_b[31:0] : r_b[{w_nidx, 5'b0} +: 32];
  assign w_nxt_ctrl = (w_nxt_op == OpMul) ? 4'b0010 : 4'b0100;

`ifdef VSEQ_MUL_ZERO_SKIP_EN
  logic [31:0] w_cur_a, w_cur_b;
  assign w_cur_a    = r_a[{r_idx, 5'b0} +: 32];
  assign w_cur_b    = r_b[{r_idx, 5'b0} +: 32];
  assign w_nxt_skip = (w_nxt_op == OpMul) && ((w_nxt_a[30:0] == '0) || (w_nxt_b[30:0] == '0));
  assign w_cap_skip = (r_op == OpMul) && ((w_cur_a[30:0] == '0) || (w_cur_b[30:0] == '0));
  assign w_skip_val = {w_cur_a[31] ^ w_cur_b[31], 31'b0};
`else
  assign w_nxt_skip = 1'b0;
  assign w_cap_skip = 1'b0;
  assign w_skip_val = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (!w_legal)        w_state_d = StResp;
          else if (w_nxt_skip) w_state_d = StCapture;
          else                 w_state_d = StIssue;
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (r_cnt == '0) w_state_d = StCapture;
      end
      StCapture: begin
        if (w_last)          w_state_d = StResp;
        else if (w_nxt_skip) w_state_d = StCapture;
        else                 w_state_d = StIssue;
      end
      StResp: begin
        if (r_rsp_valid && bus.rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_op        <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_alu_ctrl  <= '0;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_a    <= bus.cmd_a;
            r_b    <= bus.cmd_b;
            r_op   <= bus.cmd_op;
            r_idx  <= '0;
            r_mask <= '0;
            r_err  <= !w_legal;
            if (!w_legal) begin
              r_data <= '0;
            end else if (!w_nxt_skip) begin
              r_alu_ctrl <= w_nxt_ctrl;
              r_alu_in1  <= w_nxt_a;
              r_alu_in2  <= w_nxt_b;
            end
          end
        end
        StIssue: r_cnt <= (r_op == OpMul) ? CntW'(MUL_LAT - 1) : CntW'(ADD_LAT - 1);
        StWait:  r_cnt <= r_cnt - 1'b1;
        StCapture: begin
          r_data[{r_idx, 5'b0} +: 32] <= w_cap_skip ? w_skip_val : bus.alu_result;
          r_mask[r_idx]               <= w_cap_skip | bus.alu_zero;
          r_alu_ctrl                  <= '0;
          r_alu_in1                   <= '0;
          r_alu_in2                   <= '0;
          if (!w_last) begin
            r_idx <= w_nidx;
            if (!w_nxt_skip) begin
              r_alu_ctrl <= w_nxt_ctrl;
              r_alu_in1  <= w_nxt_a;
              r_alu_in2  <= w_nxt_b;
            end
          end
        end
        StResp: begin
          // First RESP cycle raises valid; it drops on the handshake as the FSM returns to idle.
          if (!r_rsp_valid)        r_rsp_valid <= 1'b1;
          else if (bus.rsp_ready)  r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready     = (r_state == StIdle);
  assign bus.alu_control   = r_alu_ctrl;
  assign bus.alu_in1       = r_alu_in1;
  assign bus.alu_in2       = r_alu_in2;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_data      = r_data;
  assign bus.rsp_zero_mask = r_mask;
  assign bus.rsp_err       = r_err;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Scoreboard bench for vec_alu_sequencer with a table-driven latency model of the FP ALU.
module tb_vec_alu_sequencer;
  localparam int unsigned VLEN    = 4;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned ADD_LAT = 3;
  localparam logic [3:0]  CtlMul  = 4'b0010;
  localparam logic [3:0]  CtlAdd  = 4'b0100;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   mask;
    logic         err;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] exp_ctrl = 4'b0000;
  logic rv_q = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  vec_alu_sequencer_if #(.VLEN(VLEN)) bus ();

  vec_alu_sequencer #(
    .VLEN   (VLEN),
    .MUL_LAT(MUL_LAT),
    .ADD_LAT(ADD_LAT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: results for the directed vectors only; anything else reads as DEADBEEF.
  function automatic logic [31:0] fpu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [67:0] key;
    key = {c, a, b};
    case (key)
      {CtlMul, 32'h40000000, 32'h40400000}: return 32'h40C00000;
      {CtlMul, 32'h3FC00000, 32'h40000000}: return 32'h40400000;
      {CtlMul, 32'hBF800000, 32'h40800000}: return 32'hC0800000;
      {CtlMul, 32'h40400000, 32'h3F000000}: return 32'h3FC00000;
      {CtlMul, 32'h80000000, 32'h40000000}: return 32'h80000000;
      {CtlAdd, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
      {CtlAdd, 32'h40000000, 32'h3F800000}: return 32'h40400000;
      {CtlAdd, 32'hC0400000, 32'h40400000}: return 32'h00000000;
      {CtlAdd, 32'h3F000000, 32'h3F000000}: return 32'h3F800000;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  logic [31:0] mul_pipe [MUL_LAT];
  logic        mul_v    [MUL_LAT];
  logic [31:0] add_pipe [ADD_LAT];
  logic        add_v    [ADD_LAT];

  always @(posedge clk) begin
    mul_pipe[0] <= fpu(bus.alu_control, bus.alu_in1, bus.alu_in2);
    mul_v[0]    <= (bus.alu_control == CtlMul);
    add_pipe[0] <= fpu(bus.alu_control, bus.alu_in1, bus.alu_in2);
    add_v[0]    <= (bus.alu_control == CtlAdd);
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe[i] <= mul_pipe[i-1];
      mul_v[i]    <= mul_v[i-1];
    end
    for (int i = 1; i < ADD_LAT; i++) begin
      add_pipe[i] <= add_pipe[i-1];
      add_v[i]    <= add_v[i-1];
    end
  end

  assign bus.alu_result = mul_v[MUL_LAT-1] ? mul_pipe[MUL_LAT-1] :
                          add_v[ADD_LAT-1] ? add_pipe[ADD_LAT-1] : 32'hDEADBEEF;
  assign bus.alu_zero   = (bus.alu_result[30:0] == 31'd0);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each rising rsp_valid pops one expectation; alu_control may only show the active op.
  always @(negedge clk) begin
    if (bus.rsp_valid && !rv_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 128'd1, 128'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, mon_e.data);
        chk("rsp_zero_mask", {124'd0, bus.rsp_zero_mask}, {124'd0, mon_e.mask});
        chk("rsp_err", {127'd0, bus.rsp_err}, {127'd0, mon_e.err});
        chk("rsp_latency", 128'(cyc - mon_e.acc), 128'(mon_e.lat));
      end
    end
    chk("alu_control_legal",
        {127'd0, (bus.alu_control == 4'b0000) || (bus.alu_control == exp_ctrl)}, 128'd1);
    rv_q <= bus.rsp_valid;
  end

  task automatic send(input logic [1:0] op, input logic [127:0] a, input logic [127:0] b,
                      input logic [3:0] ctrl, input logic push, input logic [127:0] d,
                      input logic [3:0] m, input logic e, input int lat);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("cmd_ready_timeout", 128'd0, 128'd1);
      return;
    end
    exp_ctrl      = ctrl;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    x.data = d;
    x.mask = m;
    x.err  = e;
    x.lat  = lat;
    x.acc  = cyc;
    if (push) sb.push_back(x);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.cmd_ready && !bus.rsp_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 128'd0, 128'd1);
  endtask

  localparam logic [127:0] AddA = {32'h3F000000, 32'hC0400000, 32'h40000000, 32'h3F800000};
  localparam logic [127:0] AddB = {32'h3F000000, 32'h40400000, 32'h3F800000, 32'h3F800000};
  localparam logic [127:0] AddR = {32'h3F800000, 32'h00000000, 32'h40400000, 32'h40000000};
  localparam logic [127:0] MulA = {32'h40400000, 32'hBF800000, 32'h3FC00000, 32'h40000000};
  localparam logic [127:0] MulB = {32'h3F000000, 32'h40800000, 32'h40000000, 32'h40400000};
  localparam logic [127:0] MulR = {32'h3FC00000, 32'hC0800000, 32'h40400000, 32'h40C00000};
  localparam logic [127:0] SkpA = {32'h40400000, 32'hBF800000, 32'h80000000, 32'h40000000};
  localparam logic [127:0] SkpR = {32'h3FC00000, 32'hC0800000, 32'h80000000, 32'h40C00000};
`ifdef VSEQ_MUL_ZERO_SKIP_EN
  localparam int SkpLat = 20;
`else
  localparam int SkpLat = 25;
`endif

  initial begin
    int n;
    int seen;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_cmd_ready", {127'd0, bus.cmd_ready}, 128'd1);
    chk("reset_rsp_valid", {127'd0, bus.rsp_valid}, 128'd0);
    chk("reset_alu_control", {124'd0, bus.alu_control}, 128'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ADD then MUL, both with full latency
    send(2'b01, AddA, AddB, CtlAdd, 1'b1, AddR, 4'b0100, 1'b0, 21);
    wait_idle();
    send(2'b00, MulA, MulB, CtlMul, 1'b1, MulR, 4'b0000, 1'b0, 25);
    wait_idle();

    // Abort a MUL during WAIT with an asynchronous reset
    send(2'b00, MulA, MulB, CtlMul, 1'b0, '0, 4'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_alu_control", {124'd0, bus.alu_control}, 128'd0);
    chk("abort_alu_in1", {96'd0, bus.alu_in1}, 128'd0);
    chk("abort_alu_in2", {96'd0, bus.alu_in2}, 128'd0);
    chk("abort_rsp_data", bus.rsp_data, 128'd0);
    chk("abort_rsp_mask", {124'd0, bus.rsp_zero_mask}, 128'd0);
    chk("abort_rsp_err", {127'd0, bus.rsp_err}, 128'd0);
    chk("abort_cmd_ready", {127'd0, bus.cmd_ready}, 128'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("abort_release_cmd_ready", {127'd0, bus.cmd_ready}, 128'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 128'(seen), 128'd0);

    // Backpressure: response held for 10 cycles while cmd_valid toggles
    bus.rsp_ready = 1'b0;
    send(2'b01, AddA, AddB, CtlAdd, 1'b1, AddR, 4'b0100, 1'b0, 21);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid_seen", {127'd0, bus.rsp_valid}, 128'd1);
    bus.cmd_op = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_data_stable", bus.rsp_data, AddR);
      chk("bp_rsp_valid_held", {127'd0, bus.rsp_valid}, 128'd1);
      chk("bp_cmd_ready_low", {127'd0, bus.cmd_ready}, 128'd0);
      bus.cmd_valid = ~bus.cmd_valid;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rsp_valid_drop", {127'd0, bus.rsp_valid}, 128'd0);
    chk("bp_cmd_ready_after", {127'd0, bus.cmd_ready}, 128'd1);
    repeat (10) @(negedge clk);

    // Illegal op: immediate error response, ALU untouched
    send(2'b11, MulA, MulB, 4'b0000, 1'b1, 128'd0, 4'b0000, 1'b1, 1);
    wait_idle();

    // MUL with a -0 element
    send(2'b00, SkpA, MulB, CtlMul, 1'b1, SkpR, 4'b0010, 1'b0, SkpLat);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
Initiator-side controller for the scalar floating-point ALU. It accepts one vector command (MUL or ADD over VLEN packed 32-bit elements) on a valid/ready handshake. It issues elements one at a time on the ALU's alu_control/in1/in2 interface, waits the fixed unit latency, and captures alu_result and zero_flag per element. It then returns the assembled result vector and a zero mask on a second valid/ready handshake.

Parameters:
VLEN, 4, number of 32-bit elements per command (at least 1).
MUL_LAT, 4, cycles from operand issue until the fpmul result is valid on alu_result (at least 1).
ADD_LAT, 3, cycles from operand issue until the fpadd result is valid on alu_result (at least 1).

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command offered.
cmd_ready  out  1  sequencer can accept a command.
cmd_op  in  2  2'b00 MUL, 2'b01 ADD, other values illegal.
cmd_a  in  VLEN*32  operand A vector; element i occupies [32i+31:32i].
cmd_b  in  VLEN*32  operand B vector, same packing as cmd_a.
alu_control  out  4  4'b0010 MUL, 4'b0100 ADD, 4'b0000 idle.
alu_in1  out  32  element of A currently issued.
alu_in2  out  32  element of B currently issued.
alu_result  in  32  ALU result.
alu_zero  in  1  ALU zero_flag.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer accepts the response.
rsp_data  out  VLEN*32  result vector, same packing as cmd_a.
rsp_zero_mask  out  VLEN  bit i set when result element i is zero.
rsp_err  out  1  command carried an illegal op.

Behaviour:
- Reset (rst low, asynchronous): state goes to IDLE. Every registered output is driven to 0: alu_control, alu_in1, alu_in2, rsp_valid, rsp_data, rsp_zero_mask, rsp_err. Any in-flight command is discarded.
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- cmd_ready = 1 only in IDLE. It is 1 immediately after reset is released.
- Accept (cmd_valid & cmd_ready at a rising edge):
  - Latch cmd_a, cmd_b and cmd_op; set element index idx = 0; clear rsp_zero_mask and rsp_err.
  - Legal op: go to ISSUE.
  - Illegal op: go to RESP with rsp_err = 1, rsp_data = 0, mask = 0. The ALU is never driven in this case.
- ISSUE (1 cycle):
  - Drive alu_in1 = A[idx], alu_in2 = B[idx], alu_control = the op code.
  - Load the wait counter with LAT-1, where LAT is MUL_LAT or ADD_LAT according to the op.
  - Go to WAIT.
- WAIT: decrement the counter each cycle. Leave for CAPTURE in the cycle the counter reads 0, so WAIT lasts exactly LAT cycles.
- CAPTURE (1 cycle):
  - rsp_data[idx] <= alu_result; rsp_zero_mask[idx] <= alu_zero.
  - If idx == VLEN-1, go to RESP; otherwise idx++ and go to ISSUE.
- Stability during a command: alu_control, alu_in1 and alu_in2 hold stable from ISSUE through CAPTURE of each element.
- Element timing: each element takes LAT+2 cycles. rsp_valid rises VLEN*(LAT+2)+1 cycles after the accepting edge (defaults: MUL 25, ADD 21).
- RESP:
  - rsp_valid = 1; alu_control = 4'b0000.
  - rsp_data, mask and err stay stable until rsp_valid & rsp_ready.
  - On that handshake, go to IDLE. cmd_ready rises the following cycle; a new command is never accepted in the same cycle as the response handshake.
  - If rsp_ready is already high on entry, rsp_valid is a one-cycle pulse.
- IDLE: alu_control = 0, alu_in1 = 0, alu_in2 = 0. rsp_data retains its last value while rsp_valid = 0.
- cmd_valid while busy is ignored; the command is not latched.

Optional Feature:
Macro VSEQ_MUL_ZERO_SKIP_EN.
- Defined: for MUL, if A[idx] or B[idx] has bits [30:0] == 0 (±0):
  - The element bypasses ISSUE/WAIT and is handled in one CAPTURE cycle.
  - rsp_data[idx] = {A[idx][31]^B[idx][31], 31'b0}; mask bit = 1.
  - alu_control stays 4'b0000 for that element.
  - Total latency drops by MUL_LAT+1 per skipped element.
  - ADD is unaffected.
- Undefined: every element goes through the full ISSUE/WAIT/CAPTURE path.

Test Plan:
1. Reset: assert rst low mid-WAIT of a MUL command -> all outputs 0 immediately, state IDLE; after release cmd_ready = 1 and no rsp_valid ever appears for the aborted command.
2. ADD: A = {3F000000, C0400000, 40000000, 3F800000} (elem3..0), B = {3F000000, 40400000, 3F800000, 3F800000} -> rsp_data = {3F800000, 00000000, 40400000, 40000000}, mask = 4'b0100, rsp_valid 21 cycles after accept, alu_control = 0100 while busy.
3. MUL: A = {40400000, BF800000, 3FC00000, 40000000}, B = {3F000000, 40800000, 40000000, 40400000} -> rsp_data = {3FC00000, C0800000, 40400000, 40C00000}, mask = 0, rsp_valid at cycle 25.
4. Backpressure: hold rsp_ready = 0 for 10 cycles after rsp_valid, pulse cmd_valid meanwhile -> rsp_data stable, cmd_ready = 0, no second accept; rsp_ready = 1 -> IDLE and cmd_ready = 1 the next cycle.
5. Illegal op 2'b11 -> rsp_valid with rsp_err = 1 on the cycle after accept, rsp_data = 0, alu_control never leaves 0000.
6. With VSEQ_MUL_ZERO_SKIP_EN: MUL with A[1] = 80000000, B[1] = 40000000 -> rsp_data[1] = 80000000, mask bit1 = 1, rsp_valid at cycle 20. Without the macro -> rsp_valid at cycle 25, element 1 value as returned by the ALU.
